// File: rtl/his_peak_builder_if.sv
// his_peak_builder_if: timestamp input and peak-result output of the histogram
// peak builder.
//   in_valid / in_data / in_ready : TDC timestamp stream (valid/ready)
//   out_valid / out_ready         : peak result handshake
//   out_pixel, out_peak_bin, out_peak_cnt, out_miss, out_last : result fields
// slave = the builder, master = upstream TDC and downstream consumer.
interface his_peak_builder_if #(
   parameter int TDC_W = 10,
   parameter int BIN_W = 4,
   parameter int CNT_W = 8,
   parameter int PIX_W = 2
);
   logic             in_valid;
   logic [TDC_W-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [PIX_W-1:0] out_pixel;
   logic [BIN_W-1:0] out_peak_bin;
   logic [CNT_W-1:0] out_peak_cnt;
   logic             out_miss;
   logic             out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_pixel, out_peak_bin, out_peak_cnt,
             out_miss, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_pixel, out_peak_bin, out_peak_cnt,
             out_miss, out_last
   );
endinterface

// File: rtl/his_peak_builder.sv
// his_peak_builder: multi-pixel coarse histogram builder with peak search.
// Timestamps arrive acquisition-major, then pixel, then sample. Each accepted
// timestamp bumps a saturating counter for its pixel at bin = top BIN_W bits.
// After the last sample of the frame every pixel histogram is scanned one bin
// per cycle and one peak result per pixel is streamed out, then all state is
// cleared for the next frame.
// Ports:
//   clk  - clock, rising edge
//   res  - synchronous active-high reset, aborts any frame in flight
//   bus  - his_peak_builder_if.slave (timestamp in, peak result out)
module his_peak_builder #(
   parameter int TDC_W        = 10,
   parameter int BIN_W        = 4,
   parameter int CNT_W        = 8,
   parameter int PIXEL_NUM    = 3,
   parameter int ACQ_NUM      = 4,
   parameter int DATA_NUM     = 2,
   parameter int ZERO_IS_MISS = 1
) (
   input logic              clk,
   input logic              res,
   his_peak_builder_if.slave bus
);
   localparam int NB    = 1 << BIN_W;
   localparam int PIX_W = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1;
   localparam int ACQ_W = (ACQ_NUM   > 1) ? $clog2(ACQ_NUM)   : 1;
   localparam int DAT_W = (DATA_NUM  > 1) ? $clog2(DATA_NUM)  : 1;

   typedef enum logic [1:0] {ACCUM, SCAN, OUT, CLEAR} state_t;

   state_t state;
   logic [PIXEL_NUM-1:0][NB-1:0][CNT_W-1:0] cnt;

   logic [DAT_W-1:0] dataIdx;
   logic [PIX_W-1:0] pixIdx;
   logic [ACQ_W-1:0] acqIdx;

   logic [PIX_W-1:0] scanPix;
   logic [BIN_W-1:0] scanIdx;
   logic [CNT_W-1:0] maxCnt;
   logic [BIN_W-1:0] maxBin;
   // One idle SCAN cycle after the final accept, so the result timing from the
   // last sample is NB+1 cycles while pixel-to-pixel spacing stays NB+1 too.
   logic             prime;

   logic             inReady;
   logic             outValid;
   logic [PIX_W-1:0] outPixel;
   logic [BIN_W-1:0] outBin;
   logic [CNT_W-1:0] outCnt;
   logic             outMiss;
   logic             outLast;

   assign bus.in_ready     = inReady;
   assign bus.out_valid    = outValid;
   assign bus.out_pixel    = outPixel;
   assign bus.out_peak_bin = outBin;
   assign bus.out_peak_cnt = outCnt;
   assign bus.out_miss     = outMiss;
   assign bus.out_last     = outLast;

   logic             accept;
   logic [BIN_W-1:0] inBin;
   logic             isMiss;
   logic             lastData, lastPix, lastAcq;
   logic [CNT_W-1:0] scanVal;
   logic             takeIt;
   logic [CNT_W-1:0] nextMax;
   logic [BIN_W-1:0] nextBin;

   assign accept   = bus.in_valid & inReady;
   assign inBin    = bus.in_data[TDC_W-1 -: BIN_W];
   assign isMiss   = (ZERO_IS_MISS != 0) && (bus.in_data == '0);
   assign lastData = (dataIdx == DAT_W'(DATA_NUM - 1));
   assign lastPix  = (pixIdx  == PIX_W'(PIXEL_NUM - 1));
   assign lastAcq  = (acqIdx  == ACQ_W'(ACQ_NUM - 1));

   // Bin 0 always loads the running max; later bins only on strictly greater,
   // so ties resolve to the lowest bin and an empty histogram reports bin 0.
   assign scanVal = cnt[scanPix][scanIdx];
   assign takeIt  = (scanIdx == '0) || (scanVal > maxCnt);
   assign nextMax = takeIt ? scanVal : maxCnt;
   assign nextBin = takeIt ? scanIdx : maxBin;

   always_ff @(posedge clk) begin
      if (res) begin
         state    <= ACCUM;
         cnt      <= '0;
         dataIdx  <= '0;
         pixIdx   <= '0;
         acqIdx   <= '0;
         scanPix  <= '0;
         scanIdx  <= '0;
         maxCnt   <= '0;
         maxBin   <= '0;
         prime    <= 1'b0;
         inReady  <= 1'b0;
         outValid <= 1'b0;
         outPixel <= '0;
         outBin   <= '0;
         outCnt   <= '0;
         outMiss  <= 1'b0;
         outLast  <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               inReady <= 1'b1;
               if (accept) begin
                  if (!isMiss && (cnt[pixIdx][inBin] != {CNT_W{1'b1}}))
                     cnt[pixIdx][inBin] <= cnt[pixIdx][inBin] + 1'b1;
                  if (!lastData) begin
                     dataIdx <= dataIdx + 1'b1;
                  end else begin
                     dataIdx <= '0;
                     if (!lastPix) begin
                        pixIdx <= pixIdx + 1'b1;
                     end else begin
                        pixIdx <= '0;
                        acqIdx <= lastAcq ? '0 : acqIdx + 1'b1;
                     end
                  end
                  if (lastData && lastPix && lastAcq) begin
                     state   <= SCAN;
                     inReady <= 1'b0;
                     scanPix <= '0;
                     scanIdx <= '0;
                     prime   <= 1'b1;
                  end
               end
            end
            SCAN: begin
               if (prime) begin
                  prime <= 1'b0;
               end else begin
                  maxCnt  <= nextMax;
                  maxBin  <= nextBin;
                  scanIdx <= scanIdx + 1'b1;
                  if (&scanIdx) begin
                     state    <= OUT;
                     outValid <= 1'b1;
                     outPixel <= scanPix;
                     outBin   <= nextBin;
                     outCnt   <= nextMax;
                     outMiss  <= (nextMax == '0);
                     outLast  <= (scanPix == PIX_W'(PIXEL_NUM - 1));
                  end
               end
            end
            OUT: begin
               if (bus.out_ready) begin
                  outValid <= 1'b0;
                  if (outLast) begin
                     state <= CLEAR;
                  end else begin
                     state   <= SCAN;
                     scanPix <= scanPix + 1'b1;
                  end
               end
            end
            CLEAR: begin
               cnt     <= '0;
               dataIdx <= '0;
               pixIdx  <= '0;
               acqIdx  <= '0;
               scanPix <= '0;
               scanIdx <= '0;
               state   <= ACCUM;
               inReady <= 1'b1;
            end
            default: state <= ACCUM;
         endcase
      end
   end
endmodule

// File: tb/tb_his_peak_builder.sv
// Directed bench for his_peak_builder. Three instances share clk/res:
//   u=0 default parameters, u=1 CNT_W=3/ACQ_NUM=5, u=2 ZERO_IS_MISS=0.
module tb_his_peak_builder;
   logic clk = 1'b0;
   logic res = 1'b1;
   always #5 clk = ~clk;

   his_peak_builder_if #(.TDC_W(10), .BIN_W(4), .CNT_W(8), .PIX_W(2)) ifA ();
   his_peak_builder_if #(.TDC_W(10), .BIN_W(4), .CNT_W(3), .PIX_W(2)) ifB ();
   his_peak_builder_if #(.TDC_W(10), .BIN_W(4), .CNT_W(8), .PIX_W(2)) ifC ();

   his_peak_builder #(.TDC_W(10), .BIN_W(4), .CNT_W(8), .PIXEL_NUM(3),
      .ACQ_NUM(4), .DATA_NUM(2), .ZERO_IS_MISS(1)) dutA (.clk(clk), .res(res), .bus(ifA));
   his_peak_builder #(.TDC_W(10), .BIN_W(4), .CNT_W(3), .PIXEL_NUM(3),
      .ACQ_NUM(5), .DATA_NUM(2), .ZERO_IS_MISS(1)) dutB (.clk(clk), .res(res), .bus(ifB));
   his_peak_builder #(.TDC_W(10), .BIN_W(4), .CNT_W(8), .PIXEL_NUM(3),
      .ACQ_NUM(4), .DATA_NUM(2), .ZERO_IS_MISS(0)) dutC (.clk(clk), .res(res), .bus(ifC));

   logic [2:0]       inValid = '0;
   logic [2:0]       outReady = '0;
   logic [2:0][9:0]  inData = '0;
   logic [2:0]       iReady, oValid, oMiss, oLast;
   logic [2:0][1:0]  oPix;
   logic [2:0][3:0]  oBin;
   logic [2:0][7:0]  oCnt;

   assign ifA.in_valid = inValid[0];  assign ifA.in_data = inData[0];  assign ifA.out_ready = outReady[0];
   assign ifB.in_valid = inValid[1];  assign ifB.in_data = inData[1];  assign ifB.out_ready = outReady[1];
   assign ifC.in_valid = inValid[2];  assign ifC.in_data = inData[2];  assign ifC.out_ready = outReady[2];

   assign iReady = {ifC.in_ready, ifB.in_ready, ifA.in_ready};
   assign oValid = {ifC.out_valid, ifB.out_valid, ifA.out_valid};
   assign oMiss  = {ifC.out_miss, ifB.out_miss, ifA.out_miss};
   assign oLast  = {ifC.out_last, ifB.out_last, ifA.out_last};
   assign oPix   = {ifC.out_pixel, ifB.out_pixel, ifA.out_pixel};
   assign oBin   = {ifC.out_peak_bin, ifB.out_peak_bin, ifA.out_peak_bin};
   assign oCnt   = {ifC.out_peak_cnt, {5'b0, ifB.out_peak_cnt}, ifA.out_peak_cnt};

   int vecs = 0;
   int errs = 0;

   // Results captured by read_frame; rWait[0] is cycles to the first valid,
   // rWait[i] the cycles from handshake i-1 to the next valid.
   int rWait[3], rPix[3], rBin[3], rCnt[3], rMiss[3], rLast[3], rDrop[3];
   int rRdyClr, rRdyAcc;

   // Stimulus value for sample idx of a frame (DATA_NUM=2, PIXEL_NUM=3).
   function automatic logic [9:0] sampleVal(input int mode, input int idx);
      int pix, h;
      pix = (idx / 2) % 3;
      h   = (idx / 6) * 2 + idx % 2;
      case (mode)
         1:       sampleVal = (pix == 1) ? ((h < 4) ? 10'd200 : 10'd330) : 10'd108;
         2:       sampleVal = 10'd1023;
         3:       sampleVal = (pix == 2) ? 10'd0 : 10'd108;
         default: sampleVal = 10'd108;
      endcase
   endfunction

   task automatic feed(input int u, input int total, input int mode);
      for (int i = 0; i < total; i++) begin
         int g = 0;
         inValid[u] = 1'b1;
         inData[u]  = sampleVal(mode, i);
         while (!iReady[u] && g < 100) begin @(posedge clk); #1; g++; end
         if (g >= 100) begin
            vecs++; errs++;
            $display("FAIL feed_timeout: unit %0d sample %0d never accepted", u, i);
            inValid[u] = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      inValid[u] = 1'b0;
   endtask

   task automatic read_frame(input int u, input int n);
      for (int i = 0; i < n; i++) begin
         int c = 0;
         while (!oValid[u] && c < 100) begin @(posedge clk); #1; c++; end
         rWait[i] = c;
         rPix[i] = oPix[u];  rBin[i] = oBin[u];  rCnt[i] = oCnt[u];
         rMiss[i] = oMiss[u];  rLast[i] = oLast[u];
         outReady[u] = 1'b1;
         @(posedge clk); #1;
         outReady[u] = 1'b0;
         rDrop[i] = oValid[u];
      end
      rRdyClr = iReady[u];
      @(posedge clk); #1;
      rRdyAcc = iReady[u];
   endtask

   task automatic test_reset();
      res = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      vecs++; if (iReady !== 3'b000) begin errs++; $display("FAIL reset_in_ready: got %b want 000", iReady); end
      vecs++; if (oValid !== 3'b000) begin errs++; $display("FAIL reset_out_valid: got %b want 000", oValid); end
      vecs++; if ({oPix, oBin, oCnt, oMiss, oLast} !== '0) begin errs++;
         $display("FAIL reset_out_fields: got pix %h bin %h cnt %h", oPix, oBin, oCnt); end
      res = 1'b0;
      @(posedge clk); #1;
      vecs++; if (iReady !== 3'b111) begin errs++; $display("FAIL reset_release_ready: got %b want 111", iReady); end
   endtask

   task automatic test_basic();
      feed(0, 24, 0);
      read_frame(0, 3);
      vecs++; if (rWait[0] !== 17) begin errs++; $display("FAIL basic_latency: got %0d want 17", rWait[0]); end
      for (int i = 0; i < 3; i++) begin
         vecs++; if (rPix[i] !== i || rBin[i] !== 1 || rCnt[i] !== 8 || rMiss[i] !== 0) begin errs++;
            $display("FAIL basic_result%0d: got pix %0d bin %0d cnt %0d miss %0d want %0d 1 8 0",
                     i, rPix[i], rBin[i], rCnt[i], rMiss[i], i); end
         vecs++; if (rLast[i] !== (i == 2 ? 1 : 0)) begin errs++;
            $display("FAIL basic_last%0d: got %0d", i, rLast[i]); end
         vecs++; if (rDrop[i] !== 0) begin errs++; $display("FAIL basic_valid_drop%0d: got %0d want 0", i, rDrop[i]); end
         if (i > 0) begin
            vecs++; if (rWait[i] !== 16) begin errs++; $display("FAIL basic_gap%0d: got %0d want 16", i, rWait[i]); end
         end
      end
      vecs++; if (rRdyClr !== 0 || rRdyAcc !== 1) begin errs++;
         $display("FAIL basic_clear_ready: got %0d,%0d want 0,1", rRdyClr, rRdyAcc); end
   endtask

   task automatic test_tie();
      int eBin[3] = '{1, 3, 1};
      int eCnt[3] = '{8, 4, 8};
      feed(0, 24, 1);
      read_frame(0, 3);
      for (int i = 0; i < 3; i++) begin
         vecs++; if (rPix[i] !== i || rBin[i] !== eBin[i] || rCnt[i] !== eCnt[i]) begin errs++;
            $display("FAIL tie_result%0d: got pix %0d bin %0d cnt %0d want %0d %0d %0d",
                     i, rPix[i], rBin[i], rCnt[i], i, eBin[i], eCnt[i]); end
      end
   endtask

   task automatic test_saturate();
      feed(1, 30, 2);
      read_frame(1, 3);
      vecs++; if (rWait[0] !== 17) begin errs++; $display("FAIL sat_latency: got %0d want 17", rWait[0]); end
      for (int i = 0; i < 3; i++) begin
         vecs++; if (rBin[i] !== 15 || rCnt[i] !== 7 || rMiss[i] !== 0) begin errs++;
            $display("FAIL sat_result%0d: got bin %0d cnt %0d miss %0d want 15 7 0", i, rBin[i], rCnt[i], rMiss[i]); end
      end
   endtask

   task automatic test_backpressure();
      int c = 0;
      feed(0, 24, 0);
      while (!oValid[0] && c < 100) begin @(posedge clk); #1; c++; end
      vecs++; if (c !== 17) begin errs++; $display("FAIL bp_latency: got %0d want 17", c); end
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         vecs++; if (oValid[0] !== 1'b1 || oPix[0] !== 2'd0 || oBin[0] !== 4'd1 || oCnt[0] !== 8'd8 || iReady[0] !== 1'b0) begin
            errs++; $display("FAIL bp_hold%0d: got valid %0d pix %0d bin %0d cnt %0d rdy %0d want 1 0 1 8 0",
                             k, oValid[0], oPix[0], oBin[0], oCnt[0], iReady[0]); end
      end
      outReady[0] = 1'b1;
      @(posedge clk); #1;
      outReady[0] = 1'b0;
      read_frame(0, 2);
      vecs++; if (rWait[0] !== 16 || rPix[0] !== 1 || rPix[1] !== 2) begin errs++;
         $display("FAIL bp_follow: got gap %0d pix %0d,%0d want 16 1,2", rWait[0], rPix[0], rPix[1]); end
      vecs++; if (rRdyAcc !== 1) begin errs++; $display("FAIL bp_ready_after: got %0d want 1", rRdyAcc); end
   endtask

   task automatic test_zero();
      feed(0, 24, 3);
      read_frame(0, 3);
      vecs++; if (rBin[0] !== 1 || rCnt[0] !== 8 || rMiss[0] !== 0) begin errs++;
         $display("FAIL zero_miss_pix0: got bin %0d cnt %0d miss %0d want 1 8 0", rBin[0], rCnt[0], rMiss[0]); end
      vecs++; if (rPix[2] !== 2 || rBin[2] !== 0 || rCnt[2] !== 0 || rMiss[2] !== 1) begin errs++;
         $display("FAIL zero_miss_pix2: got pix %0d bin %0d cnt %0d miss %0d want 2 0 0 1", rPix[2], rBin[2], rCnt[2], rMiss[2]); end
      feed(2, 24, 3);
      read_frame(2, 3);
      vecs++; if (rBin[1] !== 1 || rCnt[1] !== 8 || rMiss[1] !== 0) begin errs++;
         $display("FAIL zero_bin_pix1: got bin %0d cnt %0d miss %0d want 1 8 0", rBin[1], rCnt[1], rMiss[1]); end
      vecs++; if (rBin[2] !== 0 || rCnt[2] !== 8 || rMiss[2] !== 0) begin errs++;
         $display("FAIL zero_bin_pix2: got bin %0d cnt %0d miss %0d want 0 8 0", rBin[2], rCnt[2], rMiss[2]); end
   endtask

   task automatic test_reset_mid();
      feed(0, 24, 0);
      read_frame(0, 1);
      repeat (3) @(posedge clk);
      #1;
      res = 1'b1;
      @(posedge clk); #1;
      vecs++; if (oValid[0] !== 0 || oPix[0] !== 0 || oBin[0] !== 0 || oCnt[0] !== 0 || oMiss[0] !== 0 || oLast[0] !== 0) begin
         errs++; $display("FAIL midreset_out: got valid %0d pix %0d bin %0d cnt %0d want all 0",
                          oValid[0], oPix[0], oBin[0], oCnt[0]); end
      vecs++; if (iReady[0] !== 0) begin errs++; $display("FAIL midreset_ready_low: got %0d want 0", iReady[0]); end
      res = 1'b0;
      @(posedge clk); #1;
      vecs++; if (iReady[0] !== 1) begin errs++; $display("FAIL midreset_ready_high: got %0d want 1", iReady[0]); end
      feed(0, 24, 0);
      read_frame(0, 3);
      for (int i = 0; i < 3; i++) begin
         vecs++; if (rPix[i] !== i || rBin[i] !== 1 || rCnt[i] !== 8) begin errs++;
            $display("FAIL midreset_frame%0d: got pix %0d bin %0d cnt %0d want %0d 1 8", i, rPix[i], rBin[i], rCnt[i], i); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tie();
      test_saturate();
      test_backpressure();
      test_zero();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
